// File: rtl/multi_delay_pkg.sv
// Shared definitions for the multi-channel pulse timer: channel state
// encoding and the one-second tick constant used by the surrounding design.
package multi_delay_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // One second of 50 MHz clock cycles; a convenient period value for the
    // level above, never consumed by the timer logic itself.
    localparam logic [27:0] T_1S = 28'h2FA_F080;

endpackage

// File: rtl/multi_delay_pulse_timer.sv
// Single timer channel: rising-edge detect on din, two-state FSM and a
// down-counter that holds dout high for exactly 'period' cycles after an
// accepted edge. done flags the last high cycle of a pulse that ran out
// naturally (not reloaded, not cleared).
module pulse_timer
    import multi_delay_pkg::*;
#(
    parameter int N = 28
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din,
    input  logic [N-1:0] period,
    input  logic         retrig,
    input  logic         clr,
    output logic         dout,
    output logic         done
);

    state_t       r_state;
    logic [N-1:0] r_cnt;
    logic         r_prev;

    state_t       w_state_next;
    logic [N-1:0] w_cnt_next;
    logic         w_edge;
    logic         w_period_ok;
    logic         w_done;

    assign w_edge      = din & ~r_prev;
    assign w_period_ok = (period != '0);

    // State, counter and din history; prev resets high so a level already
    // present at reset release is not mistaken for an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_prev  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_prev  <= din;
        end
    end

    // Next-state, counter update and end-of-pulse strobe. The counter only
    // decrements in ACTIVE while above 1, so it can never underflow.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_done       = 1'b0;
        if (clr) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_edge && w_period_ok) begin
                        w_state_next = ACTIVE;
                        w_cnt_next   = period;
                    end
                end
                ACTIVE: begin
                    if (w_edge && retrig && w_period_ok) begin
                        w_cnt_next = period;
                    end else if (r_cnt == N'(1)) begin
                        w_state_next = IDLE;
                        w_cnt_next   = '0;
                        w_done       = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt - N'(1);
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    assign dout = (r_state == ACTIVE);
    assign done = w_done;

endmodule

// File: rtl/multi_delay.sv
// CH independent pulse timers sharing one period input; busy is high while
// any channel is producing a pulse.
module multi_delay
    import multi_delay_pkg::*;
#(
    parameter int          CH        = 4,
    parameter int          N         = 28,
    parameter logic [27:0] T_1S_PARM = T_1S
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] din,
    input  logic [N-1:0]  period,
    input  logic [CH-1:0] retrig,
    input  logic [CH-1:0] clr,
    output logic [CH-1:0] dout,
    output logic [CH-1:0] done,
    output logic          busy
);

    logic [CH-1:0] w_dout;

    // The one-second constant is exported for the level above only; this
    // empty block just keeps it referenced.
    if (T_1S_PARM == 28'd0) begin : g_t1s_zero
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        pulse_timer #(
            .N(N)
        ) u_timer (
            .clk    (clk),
            .rst    (rst),
            .din    (din[gi]),
            .period (period),
            .retrig (retrig[gi]),
            .clr    (clr[gi]),
            .dout   (w_dout[gi]),
            .done   (done[gi])
        );
    end

    assign dout = w_dout;
    assign busy = |w_dout;

endmodule

// File: tb/tb_multi_delay.sv
// Directed bench for multi_delay. Each cycle c: inputs are applied at the
// falling edge, outputs are checked 1 ns later against hand-written
// expected windows; the rising edge then ends cycle c.
module tb_multi_delay;

    logic        clk;
    logic        rst;
    logic [3:0]  din;
    logic [27:0] period;
    logic [3:0]  retrig;
    logic [3:0]  clr;
    logic [3:0]  dout;
    logic [3:0]  done;
    logic        busy;

    int n_checks;
    int n_fail;

    multi_delay dut (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .period (period),
        .retrig (retrig),
        .clr    (clr),
        .dout   (dout),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input int c, input logic [3:0] e_dout, input logic [3:0] e_done);
        check($sformatf("%s c%0d dout", tag, c), {28'd0, dout}, {28'd0, e_dout});
        check($sformatf("%s c%0d done", tag, c), {28'd0, done}, {28'd0, e_done});
        check($sformatf("%s c%0d busy", tag, c), {31'd0, busy}, {31'd0, |e_dout});
        $display("%s cycle %0d: din=%b clr=%b period=%0d dout=%b done=%b busy=%b",
                 tag, c, din, clr, period, dout, done, busy);
    endtask

    initial begin
        logic [3:0] e_dout;
        logic [3:0] e_done;
        n_checks = 0;
        n_fail   = 0;
        rst    = 1'b1;
        din    = 4'b0000;
        period = 28'd8;
        retrig = 4'b0010;
        clr    = 4'b0000;

        // Held in reset: everything quiet.
        repeat (3) @(negedge clk);
        #1;
        check_outs("reset", 0, 4'b0000, 4'b0000);

        // Phase 1: basic / non-retrig / retrig / clear / zero period / concurrency.
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c <= 34; c++) begin
            if (c != 0) @(negedge clk);
            din[0] = (c >= 10 && c <= 12) || (c >= 14 && c <= 16) || (c >= 18 && c <= 19);
            din[1] = (c >= 10 && c <= 11) || (c >= 14 && c <= 15) || (c >= 18 && c <= 19) || (c >= 23 && c <= 24);
            din[2] = (c >= 10 && c <= 11) || (c >= 30 && c <= 31);
            din[3] = (c >= 10 && c <= 11);
            period = (c == 18) ? 28'd5 : (c == 23) ? 28'd3 : (c == 30) ? 28'd0 : 28'd8;
            clr    = (c == 13) ? 4'b0100 : 4'b0000;
            #1;
            e_dout[0] = (c >= 11 && c <= 18);
            e_dout[1] = (c >= 11 && c <= 26);
            e_dout[2] = (c >= 11 && c <= 13);
            e_dout[3] = (c >= 11 && c <= 18);
            e_done[0] = (c == 18);
            e_done[1] = (c == 26);
            e_done[2] = 1'b0;
            e_done[3] = (c == 18);
            check_outs("ph1", c, e_dout, e_done);
        end

        // Phase 2: din[3] held high across reset must not trigger.
        @(negedge clk);
        din    = 4'b1000;
        clr    = 4'b0000;
        retrig = 4'b0000;
        period = 28'd4;
        rst    = 1'b1;
        #1;
        check_outs("rst2", 0, 4'b0000, 4'b0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c <= 18; c++) begin
            if (c != 0) @(negedge clk);
            din[3] = (c != 5);
            din[0] = (c >= 15);
            period = (c == 15) ? 28'd6 : 28'd4;
            #1;
            e_dout    = 4'b0000;
            e_done    = 4'b0000;
            e_dout[3] = (c >= 7 && c <= 10);
            e_done[3] = (c == 10);
            e_dout[0] = (c >= 16 && c <= 21);
            check_outs("ph2", c, e_dout, e_done);
        end

        // Reset mid-pulse of channel 0: outputs drop without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check_outs("async_rst", 18, 4'b0000, 4'b0000);
        @(negedge clk);
        #1;
        check_outs("rst_hold", 19, 4'b0000, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
